nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-word adder that adds WIDTH-bit operands one 4-bit nibble per clock, LSB nibble first.
- Each nibble goes through a combinational 4-bit carry-lookahead slice; the nibble carry-out is registered and becomes the next nibble's carry-in.
- Valid/ready on both sides. Used where a full-width adder costs too much area and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived local constant; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  A+B+cin, low WIDTH bits.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow = (carry into MSB) XOR cout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - On rst assertion: state=IDLE, operand regs, sum, cout, ovf, carry reg and nibble index all clear to 0, out_valid=0.
  - in_ready=0 while rst is high.
  - Reset mid-RUN or mid-DONE discards the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture A, B; carry reg<=cin; idx<=0; sum<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds A[4*idx+:4], B[4*idx+:4] and the carry reg.
  - sum[4*idx+:4]<=slice sum; carry reg<=slice cout; idx<=idx+1.
  - When idx==NIBBLES-1: also cout<=slice cout; ovf<=slice c3 XOR slice cout; go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable until out_ready.
  - On out_ready: go to IDLE, out_valid=0 next cycle.
  - in_valid is ignored (in_ready=0).
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one op per NIBBLES+2 cycles with out_ready held high. There is no overlap between ops, so one IDLE bubble is required.
- Arithmetic:
  - Unsigned modulo 2^WIDTH for sum; cout is bit WIDTH.
  - The carry chain crosses all nibbles through the carry reg; the all-propagate case (e.g. FFFF+0+1) must ripple correctly.
- Outputs:
  - sum, cout, ovf, out_valid come directly from registers.
  - in_ready is decoded from state (and ~rst) only, with no combinational path from in_valid.
  - sum is don't-care while out_valid=0 but must not glitch in DONE.
- idx width: clog2(NIBBLES); no wrap beyond NIBBLES-1.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, RUN, DONE).
  - NIBBLE_W=4 constant.
  - A WIDTH%4==0 check helper.
- Sub-module cla4_slice (combinational):
  - Inputs a[3:0], b[3:0], ci.
  - Outputs s[3:0], co, c3 (carry into bit 3).
  - Uses P=a^b, G=a&b with a flattened lookahead equation per carry.
  - Instantiated once and time-multiplexed by idx.

Test Plan:
- Reset: hold rst 3 cycles -> out_valid=0, sum=0, cout=0, in_ready=0. After release -> in_ready=1 next cycle.
- A=0x1234, B=0x4321, cin=0 -> after exactly 4 cycles out_valid=1, sum=0x5555, cout=0, ovf=0.
- A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (full propagate across all 4 nibbles).
- A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Backpressure:
  - A=0xABCD, B=0x1111 with out_ready=0 for 6 cycles -> out_valid stays 1, sum=0xBCDE stable.
  - in_valid pulses during this window are ignored.
  - After out_ready=1 -> IDLE; the next op 0x0001+0x0001 gives 0x0002.
- Reset mid-RUN: accept 0x8888+0x8888, assert rst after 2 RUN cycles -> all outputs 0, no out_valid. The next op 0x8888+0x8888 gives sum=0x1110, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the operand-width legality check.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Operands are split into whole nibbles and need at least two of them.
    function automatic bit width_ok(input int unsigned width);
        return ((width % NIBBLE_W) == 0) && (width >= 2 * NIBBLE_W);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// Also exposes the carry into bit 3 so the top can derive signed overflow.
module cla4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic                c1;
    logic                c2;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of products; no ripple between bit positions.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder processing one nibble per clock, LSB nibble first.
// A single lookahead slice is reused every cycle; the carry is held in a register between nibbles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [IDX_W+1:0]    nib_base;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic                slice_c3;

    assign nib_base = {idx_q, 2'b00};
    assign slice_a  = a_q[nib_base +: NIBBLE_W];
    assign slice_b  = b_q[nib_base +: NIBBLE_W];

    cla4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // Depends only on state and reset so there is no in_valid -> in_ready path.
    assign in_ready = (state_q == StIdle) && !rst;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[nib_base +: NIBBLE_W] = slice_s;
                carry_d                     = slice_co;
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_co;
                    ovf_d       = slice_c3 ^ slice_co;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder with hand-computed results.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec;
    int n_err;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for a single accepting edge, then check latency.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                            input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        cin      = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [15:0] es, input logic ec, input logic eo,
                             input string tag);
        step();
        step();
        step();
        check_val({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        step();
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_sum"}, 32'(sum), 32'(es));
        check_val({tag, "_cout"}, 32'(cout), 32'(ec));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        cin       = 1'b0;

        // Reset held for three cycles.
        repeat (3) step();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        start_op(16'h1234, 16'h4321, 1'b0, "basic");
        check_val("basic_busy", 32'(in_ready), 32'd0);
        finish_op(16'h5555, 1'b0, 1'b0, "basic");

        start_op(16'hFFFF, 16'h0000, 1'b1, "ripple");
        finish_op(16'h0000, 1'b1, 1'b0, "ripple");

        start_op(16'h7FFF, 16'h0001, 1'b0, "ovf");
        finish_op(16'h8000, 1'b0, 1'b1, "ovf");

        // Backpressure: result held while in_valid pulses are ignored.
        start_op(16'hABCD, 16'h1111, 1'b0, "bp");
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            A        = 16'h0F0F;
            B        = 16'hF0F0;
            in_valid = (i % 2 == 0);
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_sum", 32'(sum), 32'h0000BCDE);
            check_val("bp_cout", 32'(cout), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("bp_release", 32'(out_valid), 32'd0);
        start_op(16'h0001, 16'h0001, 1'b0, "after_bp");
        finish_op(16'h0002, 1'b0, 1'b0, "after_bp");

        // Reset in the middle of RUN discards the operation.
        start_op(16'h8888, 16'h8888, 1'b0, "mid");
        step();
        step();
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_sum", 32'(sum), 32'd0);
        check_val("mid_rst_cout", 32'(cout), 32'd0);
        check_val("mid_rst_ovf", 32'(ovf), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("mid_no_valid", 32'(out_valid), 32'd0);
        end
        start_op(16'h8888, 16'h8888, 1'b0, "redo");
        finish_op(16'h1110, 1'b1, 1'b1, "redo");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
